seq_chunk_adder: RTL and testbench

- Parametrised multi-cycle adder. Adds two WIDTH-bit operands plus carry-in by rippling a CHUNK-bit slice per clock, low slice first.
- Next-generation arithmetic block for the datapath: trades latency for a narrow adder slice.
- Adds a start/busy/done handshake, registered results and signed-overflow detection.

---
 rtl/seq_chunk_adder.sv | 119 +++++++++++
 tb/tb_seq_chunk_adder.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/seq_chunk_adder.sv
// Multi-cycle adder that ripples one CHUNK-bit slice per clock, low slice first.
// Optional subtract mode is enabled by defining SEQ_CHUNK_ADDER_SUB_EN.
module seq_chunk_adder #(
    parameter int WIDTH = 16,
    parameter int CHUNK = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             ci,
`ifdef SEQ_CHUNK_ADDER_SUB_EN
    input  logic             sub,
`endif
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             co,
    output logic             ovf
);

    localparam int N     = WIDTH / CHUNK;
    localparam int CNT_W = (N > 1) ? $clog2(N) : 1;

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] RUN  = 1'b1;

    logic [0:0]       state_reg;
    logic [WIDTH-1:0] a_reg;
    logic [WIDTH-1:0] b_reg;
    logic [WIDTH-1:0] res_reg;
    logic [WIDTH-1:0] res_next;
    logic             carry_reg;
    logic [CNT_W-1:0] cnt_reg;
    logic             last_slice;
    logic             done_reg;
    logic [WIDTH-1:0] sum_reg;
    logic             co_reg;
    logic             ovf_reg;

    logic [CHUNK-1:0] a_cur;
    logic [CHUNK-1:0] b_cur;
    logic [CHUNK-1:0] slice_sum;
    logic [CHUNK:0]   chain;

    // Operands shift right one slice per cycle, so the active slice is always the low bits.
    assign a_cur    = a_reg[CHUNK-1:0];
    assign b_cur    = b_reg[CHUNK-1:0];
    assign chain[0] = carry_reg;

    generate
        for (genvar gi = 0; gi < CHUNK; gi++) begin : g_ripple
            assign slice_sum[gi] = a_cur[gi] ^ b_cur[gi] ^ chain[gi];
            assign chain[gi+1]   = (a_cur[gi] & b_cur[gi]) | (chain[gi] & (a_cur[gi] ^ b_cur[gi]));
        end
    endgenerate

    // Each new slice enters at the top; after N steps the result is fully aligned.
    assign res_next   = (res_reg >> CHUNK) | (WIDTH'(slice_sum) << (WIDTH - CHUNK));
    assign last_slice = (cnt_reg == CNT_W'(N - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
            a_reg     <= '0;
            b_reg     <= '0;
            res_reg   <= '0;
            carry_reg <= 1'b0;
            cnt_reg   <= '0;
            done_reg  <= 1'b0;
            sum_reg   <= '0;
            co_reg    <= 1'b0;
            ovf_reg   <= 1'b0;
        end else begin
            done_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (start) begin
                        a_reg   <= a;
                        res_reg <= '0;
                        cnt_reg <= '0;
`ifdef SEQ_CHUNK_ADDER_SUB_EN
                        b_reg     <= sub ? ~b : b;
                        carry_reg <= sub ? 1'b1 : ci;
`else
                        b_reg     <= b;
                        carry_reg <= ci;
`endif
                        state_reg <= RUN;
                    end
                end
                RUN: begin
                    a_reg     <= a_reg >> CHUNK;
                    b_reg     <= b_reg >> CHUNK;
                    res_reg   <= res_next;
                    carry_reg <= chain[CHUNK];
                    cnt_reg   <= cnt_reg + 1'b1;
                    if (last_slice) begin
                        sum_reg   <= res_next;
                        co_reg    <= chain[CHUNK];
                        // Carry into the MSB is the carry into the top bit of the last slice.
                        ovf_reg   <= chain[CHUNK] ^ chain[CHUNK-1];
                        done_reg  <= 1'b1;
                        state_reg <= IDLE;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign busy = (state_reg == RUN);
    assign done = done_reg;
    assign sum  = sum_reg;
    assign co   = co_reg;
    assign ovf  = ovf_reg;

endmodule

// File: tb/tb_seq_chunk_adder.sv
// Scoreboard bench for seq_chunk_adder: stimulus pushes expected results, a monitor pops on done.
// Subtract cases are exercised when SEQ_CHUNK_ADDER_SUB_EN is defined.
module tb_seq_chunk_adder;

    localparam int WIDTH = 16;
    parameter int  CHUNK = 4;
    localparam int N     = WIDTH / CHUNK;
`ifdef SEQ_CHUNK_ADDER_SUB_EN
    localparam bit HAS_SUB = 1'b1;
`else
    localparam bit HAS_SUB = 1'b0;
`endif

    logic             clk   = 1'b0;
    logic             rst_n = 1'b1;
    logic             start = 1'b0;
    logic             ci    = 1'b0;
    logic [WIDTH-1:0] a     = '0;
    logic [WIDTH-1:0] b     = '0;
`ifdef SEQ_CHUNK_ADDER_SUB_EN
    logic             sub   = 1'b0;
`endif
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             co;
    logic             ovf;

    seq_chunk_adder #(.WIDTH(WIDTH), .CHUNK(CHUNK)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .a     (a),
        .b     (b),
        .ci    (ci),
`ifdef SEQ_CHUNK_ADDER_SUB_EN
        .sub   (sub),
`endif
        .busy  (busy),
        .done  (done),
        .sum   (sum),
        .co    (co),
        .ovf   (ovf)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int               due;
        logic [WIDTH-1:0] sum;
        logic             co;
        logic             ovf;
    } exp_t;

    exp_t             q[$];
    logic [WIDTH-1:0] last_sum = '0;
    logic             last_co  = 1'b0;
    logic             last_ovf = 1'b0;
    int               checks   = 0;
    int               passes   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    endtask

    // Reference: plain integer arithmetic, signed overflow from operand/result signs.
    function automatic exp_t model(input logic [WIDTH-1:0] ta, input logic [WIDTH-1:0] tb_,
                                   input logic tci, input logic tsub);
        exp_t             r;
        logic [WIDTH:0]   full;
        logic [WIDTH-1:0] beff;
        logic             cin;
        beff  = tsub ? ~tb_ : tb_;
        cin   = tsub ? 1'b1 : tci;
        full  = {1'b0, ta} + {1'b0, beff} + (WIDTH+1)'(cin);
        r.due = 0;
        r.sum = full[WIDTH-1:0];
        r.co  = full[WIDTH];
        r.ovf = (ta[WIDTH-1] == beff[WIDTH-1]) && (r.sum[WIDTH-1] != ta[WIDTH-1]);
        return r;
    endfunction

    // Monitor: done must appear exactly at the due cycle; outputs hold otherwise.
    always @(negedge clk) begin
        if (rst_n) begin
            if (q.size() > 0 && cyc == q[0].due) begin
                check("done_pulse", done, 1);
                check("busy_at_done", busy, 0);
                check("sum", sum, q[0].sum);
                check("co", co, q[0].co);
                check("ovf", ovf, q[0].ovf);
                last_sum = q[0].sum;
                last_co  = q[0].co;
                last_ovf = q[0].ovf;
                void'(q.pop_front());
            end else begin
                check("done_low", done, 0);
                check("busy", busy, (q.size() > 0) ? 1 : 0);
                check("sum_hold", sum, last_sum);
                check("co_hold", co, last_co);
                check("ovf_hold", ovf, last_ovf);
            end
        end
    end

    // mode 0: quiet during RUN, 1: random start pulses/operands, 2: start held high
    task automatic issue(input logic [WIDTH-1:0] ta, input logic [WIDTH-1:0] tb_,
                         input logic tci, input logic tsub, input int mode);
        exp_t e;
        a = ta; b = tb_; ci = tci; start = 1'b1;
`ifdef SEQ_CHUNK_ADDER_SUB_EN
        sub = tsub;
`endif
        @(posedge clk); #1;
        e     = model(ta, tb_, tci, tsub);
        e.due = cyc + N;
        q.push_back(e);
        $display("op a=%h b=%h ci=%0d sub=%0d accepted@%0d exp sum=%h co=%0d ovf=%0d",
                 ta, tb_, tci, tsub, cyc, e.sum, e.co, e.ovf);
        start = 1'b0;
        for (int k = 0; k < N; k++) begin
            if (mode != 0) begin
                start = (mode == 2) ? 1'b1 : 1'($urandom_range(0, 1));
                a     = WIDTH'($urandom);
                b     = WIDTH'($urandom);
                ci    = 1'($urandom);
            end
            @(posedge clk); #1;
        end
        start = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        #2 rst_n = 1'b0;
        #1;
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_sum", sum, 0);
        check("rst_co", co, 0);
        check("rst_ovf", ovf, 0);
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;
        idle(1);

        issue(16'h1234, 16'h4321, 1'b0, 1'b0, 0);
        idle(2);
        issue(16'hFFFF, 16'h0001, 1'b0, 1'b0, 0);
        issue(16'h7FFF, 16'h0000, 1'b1, 1'b0, 0);
        issue(16'h0001, 16'h0001, 1'b0, 1'b0, 1);
        idle(1);

        // Abort an operation partway through RUN with an asynchronous reset.
        begin
            exp_t e;
            a = 16'h0F0F; b = 16'h1111; ci = 1'b0; start = 1'b1;
            @(posedge clk); #1;
            e     = model(16'h0F0F, 16'h1111, 1'b0, 1'b0);
            e.due = cyc + N;
            q.push_back(e);
            start = 1'b0;
            @(posedge clk); #1;
            rst_n = 1'b0;
            #1;
            $display("reset asserted mid-run at cycle %0d", cyc);
            check("abort_busy", busy, 0);
            check("abort_done", done, 0);
            check("abort_sum", sum, 0);
            check("abort_co", co, 0);
            check("abort_ovf", ovf, 0);
            q.delete();
            last_sum = '0; last_co = 1'b0; last_ovf = 1'b0;
            #1 rst_n = 1'b1;
        end
        idle(2 * N + 2);
        issue(16'h1234, 16'h4321, 1'b0, 1'b0, 0);

        for (int i = 0; i < 6; i++)
            issue(WIDTH'($urandom), WIDTH'($urandom), 1'($urandom), 1'b0, 2);
        idle(1);

        if (HAS_SUB) begin
            issue(16'h0005, 16'h0007, 1'b0, 1'b1, 0);
            issue(16'h8000, 16'h0001, 1'b0, 1'b1, 0);
            issue(16'h1234, 16'h4321, 1'b1, 1'b0, 0);
        end

        for (int i = 0; i < 25; i++) begin
            issue(WIDTH'($urandom), WIDTH'($urandom), 1'($urandom),
                  HAS_SUB ? 1'($urandom) : 1'b0, int'($urandom_range(0, 2)));
            idle(int'($urandom_range(0, 2)));
        end

        idle(N + 3);
        check("queue_drained", q.size(), 0);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
